video_timing: RTL and testbench

Generates the GPU's raster timing at 12.5875 MHz, half the 640x480@60 VGA pixel clock. It drives the `current_x`, `current_y` and `writable` inputs of the background and sprite layers, and the VGA `hsync`/`vsync` pins. Each 640x480 frame is scanned as 320x480 clocks, with lines doubled, giving the 256x240 game area centred horizontally. It also signals vertical blank to the CPU interface so VRAM writes are only accepted while `writable` is high.

---
 rtl/gpu_timing_pkg.sv | 50 +++++
 rtl/wrap_counter.sv | 32 +++
 rtl/video_timing.sv | 116 +++++++++++
 tb/tb_video_timing.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_timing_pkg.sv
// Shared raster constants, counter widths and the registered output bundle for video_timing.
package gpu_timing_pkg;

    localparam int HCOUNT_W = 9;
    localparam int VCOUNT_W = 10;
    localparam int GAME_W   = 256;

    localparam int H_VISIBLE_DFLT = 320;
    localparam int H_FRONT_DFLT   = 8;
    localparam int H_SYNC_DFLT    = 48;
    localparam int H_BACK_DFLT    = 24;
    localparam int V_VISIBLE_DFLT = 480;
    localparam int V_FRONT_DFLT   = 10;
    localparam int V_SYNC_DFLT    = 2;
    localparam int V_BACK_DFLT    = 33;
    localparam int X_OFFSET_DFLT  = 32;

    localparam int H_TOTAL_DFLT      = H_VISIBLE_DFLT + H_FRONT_DFLT + H_SYNC_DFLT + H_BACK_DFLT;
    localparam int V_TOTAL_DFLT      = V_VISIBLE_DFLT + V_FRONT_DFLT + V_SYNC_DFLT + V_BACK_DFLT;
    localparam int H_SYNC_START_DFLT = H_VISIBLE_DFLT + H_FRONT_DFLT;
    localparam int H_SYNC_END_DFLT   = H_SYNC_START_DFLT + H_SYNC_DFLT;
    localparam int V_SYNC_START_DFLT = V_VISIBLE_DFLT + V_FRONT_DFLT;
    localparam int V_SYNC_END_DFLT   = V_SYNC_START_DFLT + V_SYNC_DFLT;

    typedef struct packed {
        logic [7:0] current_x;
        logic [7:0] current_y;
        logic       visible;
        logic       writable;
        logic       vblank_start;
        logic       hsync;
        logic       vsync;
    } timing_t;

    localparam timing_t TIMING_RESET = '{
        current_x:    8'd0,
        current_y:    8'd0,
        visible:      1'b0,
        writable:     1'b0,
        vblank_start: 1'b0,
        hsync:        1'b1,
        vsync:        1'b1
    };

    // Half-open interval test [lo, hi).
    function automatic logic in_range(input int value, input int lo, input int hi);
        return (value >= lo) && (value < hi);
    endfunction

endpackage

// File: rtl/wrap_counter.sv
// Free-running up counter that returns to zero after TERMINAL; exposes its next value for zero-lag decode.
module wrap_counter #(
    parameter int               WIDTH    = 9,
    parameter logic [WIDTH-1:0] TERMINAL = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] next_count,
    output logic             wrap
);

    assign wrap = en && (count == TERMINAL);

    always_comb begin
        next_count = count;
        if (en) begin
            next_count = wrap ? '0 : count + WIDTH'(1);
        end
    end

    // NOTE: sequential state is written with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else begin
            count <= next_count;
        end
    end

endmodule

// File: rtl/video_timing.sv
// Raster timing for a 320x480-clock scan of 640x480@60 with a centred 256x240 game area.
// Optional frame_count port is enabled by defining VIDEO_TIMING_FRAME_COUNTER_EN.
module video_timing
    import gpu_timing_pkg::*;
#(
    parameter int H_VISIBLE = H_VISIBLE_DFLT,
    parameter int H_FRONT   = H_FRONT_DFLT,
    parameter int H_SYNC    = H_SYNC_DFLT,
    parameter int H_BACK    = H_BACK_DFLT,
    parameter int V_VISIBLE = V_VISIBLE_DFLT,
    parameter int V_FRONT   = V_FRONT_DFLT,
    parameter int V_SYNC    = V_SYNC_DFLT,
    parameter int V_BACK    = V_BACK_DFLT,
    parameter int X_OFFSET  = X_OFFSET_DFLT
) (
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] current_x,
    output logic [7:0] current_y,
    output logic       visible,
    output logic       writable,
    output logic       vblank_start,
    output logic       hsync,
    output logic       vsync
`ifdef VIDEO_TIMING_FRAME_COUNTER_EN
    ,
    output logic [7:0] frame_count
`endif
);

    localparam int H_TOTAL      = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL      = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int H_SYNC_START = H_VISIBLE + H_FRONT;
    localparam int V_SYNC_START = V_VISIBLE + V_FRONT;

    logic [HCOUNT_W-1:0] h_count, h_next;
    logic [VCOUNT_W-1:0] v_count, v_next;
    logic                h_wrap, v_wrap;
    int                  h_int, v_int;
    timing_t             timing_d, timing_q;

    wrap_counter #(
        .WIDTH    (HCOUNT_W),
        .TERMINAL (HCOUNT_W'(H_TOTAL - 1))
    ) u_hcount (
        .clk        (clk),
        .rst        (rst),
        .en         (1'b1),
        .count      (h_count),
        .next_count (h_next),
        .wrap       (h_wrap)
    );

    wrap_counter #(
        .WIDTH    (VCOUNT_W),
        .TERMINAL (VCOUNT_W'(V_TOTAL - 1))
    ) u_vcount (
        .clk        (clk),
        .rst        (rst),
        .en         (h_wrap),
        .count      (v_count),
        .next_count (v_next),
        .wrap       (v_wrap)
    );

    // Decode runs on the next-state counters only; the present counts are not needed here.
    logic unused_ok;
    assign unused_ok = &{1'b0, h_count, v_count, v_wrap};

    assign h_int = int'(h_next);
    assign v_int = int'(v_next);

    // NOTE: the default assignment first keeps always_comb free of inferred latches.
    always_comb begin
        timing_d              = TIMING_RESET;
        timing_d.visible      = in_range(h_int, X_OFFSET, X_OFFSET + GAME_W) && (v_int < V_VISIBLE);
        if (timing_d.visible) begin
            timing_d.current_x = 8'(h_next - HCOUNT_W'(X_OFFSET));
        end
        if (v_int < V_VISIBLE) begin
            timing_d.current_y = v_next[8:1];
        end
        timing_d.writable     = (v_int >= V_VISIBLE);
        timing_d.vblank_start = (h_int == 0) && (v_int == V_VISIBLE);
        timing_d.hsync        = !in_range(h_int, H_SYNC_START, H_SYNC_START + H_SYNC);
        timing_d.vsync        = !in_range(v_int, V_SYNC_START, V_SYNC_START + V_SYNC);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            timing_q <= TIMING_RESET;
        end else begin
            timing_q <= timing_d;
        end
    end

    assign current_x    = timing_q.current_x;
    assign current_y    = timing_q.current_y;
    assign visible      = timing_q.visible;
    assign writable     = timing_q.writable;
    assign vblank_start = timing_q.vblank_start;
    assign hsync        = timing_q.hsync;
    assign vsync        = timing_q.vsync;

`ifdef VIDEO_TIMING_FRAME_COUNTER_EN
    // Steps on the same edge that raises vblank_start, wrapping naturally at 8 bits.
    always_ff @(posedge clk) begin
        if (!rst) begin
            frame_count <= 8'd0;
        end else if (timing_d.vblank_start) begin
            frame_count <= frame_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_video_timing.sv
// Self-checking bench for video_timing: a default-geometry instance plus a shrunken-geometry
// instance so whole frames (vblank, wraps, frame_count) fit in a short run.
module tb_video_timing;

    typedef struct packed {
        int hv; int hf; int hs; int hb;
        int vv; int vf; int vs; int vb;
        int xo;
    } geom_t;

    localparam geom_t FULL  = '{320, 8, 48, 24, 480, 10, 2, 33, 32};
    localparam geom_t SMALL = '{8, 2, 2, 2, 6, 1, 1, 1, 2};
    localparam int SMALL_FRAME = 14 * 9;

    typedef struct {
        bit         sel;    // 0: default instance, 1: small instance
        int         t;
        logic [7:0] cx;
        logic [7:0] cy;
        logic       vis;
        logic       wr;
        logic       vb;
        logic       hs;
        logic       vs;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] f_cx, f_cy, s_cx, s_cy;
    logic       f_vis, f_wr, f_vb, f_hs, f_vs;
    logic       s_vis, s_wr, s_vb, s_hs, s_vs;
    logic [7:0] f_fc, s_fc;

    video_timing u_full (
        .clk          (clk),
        .rst          (rst),
        .current_x    (f_cx),
        .current_y    (f_cy),
        .visible      (f_vis),
        .writable     (f_wr),
        .vblank_start (f_vb),
        .hsync        (f_hs),
        .vsync        (f_vs)
`ifdef VIDEO_TIMING_FRAME_COUNTER_EN
        ,
        .frame_count  (f_fc)
`endif
    );

    video_timing #(
        .H_VISIBLE (8), .H_FRONT (2), .H_SYNC (2), .H_BACK (2),
        .V_VISIBLE (6), .V_FRONT (1), .V_SYNC (1), .V_BACK (1),
        .X_OFFSET  (2)
    ) u_small (
        .clk          (clk),
        .rst          (rst),
        .current_x    (s_cx),
        .current_y    (s_cy),
        .visible      (s_vis),
        .writable     (s_wr),
        .vblank_start (s_vb),
        .hsync        (s_hs),
        .vsync        (s_vs)
`ifdef VIDEO_TIMING_FRAME_COUNTER_EN
        ,
        .frame_count  (s_fc)
`endif
    );

`ifndef VIDEO_TIMING_FRAME_COUNTER_EN
    assign f_fc = 8'd0;
    assign s_fc = 8'd0;
`endif

    int checks   = 0;
    int failures = 0;
    int t        = 0;     // clocks since reset release, per the bench's own reset driving
    bit stats_on = 1'b0;
    int line0_hs_low, line0_vis, sf_wr, sf_vb, sf_vs_low;

    localparam logic [28:0] RESET_VEC = 29'h3;   // zero everywhere, hsync = vsync = 1

    function automatic logic [28:0] full_vec();
        return {f_fc, f_cx, f_cy, f_vis, f_wr, f_vb, f_hs, f_vs};
    endfunction

    function automatic logic [28:0] small_vec();
        return {s_fc, s_cx, s_cy, s_vis, s_wr, s_vb, s_hs, s_vs};
    endfunction

    // Reference: position and frame number straight from the elapsed clock count.
    function automatic logic [28:0] model(input geom_t g, input int tt);
        int ht, vt, h, v;
        logic [7:0] cx, cy, fc;
        logic vis, wr, vb, hs, vs;
        ht  = g.hv + g.hf + g.hs + g.hb;
        vt  = g.vv + g.vf + g.vs + g.vb;
        h   = tt % ht;
        v   = (tt / ht) % vt;
        vis = (h >= g.xo) && (h < g.xo + 256) && (v < g.vv);
        cx  = vis ? 8'(h - g.xo) : 8'd0;
        cy  = (v < g.vv) ? 8'(v / 2) : 8'd0;
        wr  = (v >= g.vv);
        vb  = (h == 0) && (v == g.vv);
        hs  = !((h >= g.hv + g.hf) && (h < g.hv + g.hf + g.hs));
        vs  = !((v >= g.vv + g.vf) && (v < g.vv + g.vf + g.vs));
        fc  = 8'd0;
`ifdef VIDEO_TIMING_FRAME_COUNTER_EN
        begin
            int first;
            first = g.vv * ht;
            if (tt >= first) fc = 8'((tt - first) / (ht * vt) + 1);
        end
`endif
        return {fc, cx, cy, vis, wr, vb, hs, vs};
    endfunction

    task automatic check(input string name, input logic [28:0] act, input logic [28:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s t=%0d actual=%h expected=%h", name, t, act, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) t++;
        else t = 0;
        @(negedge clk);
        check("full_cycle", full_vec(), model(FULL, t));
        check("small_cycle", small_vec(), model(SMALL, t));
        if (stats_on) begin
            if (t < 400) begin
                if (!f_hs) line0_hs_low++;
                if (f_vis) line0_vis++;
            end
            if (t < SMALL_FRAME) begin
                if (s_wr) sf_wr++;
                if (s_vb) sf_vb++;
                if (!s_vs) sf_vs_low++;
            end
        end
    endtask

    task automatic run_to(input int target);
        while (t < target) tick();
    endtask

    task automatic reset_pulse(input int n);
        rst = 1'b0;
        for (int i = 0; i < n; i++) begin
            tick();
            check("reset_full", full_vec(), RESET_VEC);
            check("reset_small", small_vec(), RESET_VEC);
        end
        rst = 1'b1;
    endtask

    vec_t vecs[20];

    initial begin
        //          sel  t     cx    cy   vis wr vb hs vs
        vecs[0]  = '{0, 0,    8'd0,  8'd0, 0, 0, 0, 1, 1};
        vecs[1]  = '{0, 31,   8'd0,  8'd0, 0, 0, 0, 1, 1};
        vecs[2]  = '{0, 32,   8'd0,  8'd0, 1, 0, 0, 1, 1};
        vecs[3]  = '{0, 33,   8'd1,  8'd0, 1, 0, 0, 1, 1};
        vecs[4]  = '{1, 83,   8'd11, 8'd2, 1, 0, 0, 1, 1};
        vecs[5]  = '{1, 84,   8'd0,  8'd0, 0, 1, 1, 1, 1};
        vecs[6]  = '{1, 98,   8'd0,  8'd0, 0, 1, 0, 1, 0};
        vecs[7]  = '{1, 125,  8'd0,  8'd0, 0, 1, 0, 1, 1};
        vecs[8]  = '{1, 126,  8'd0,  8'd0, 0, 0, 0, 1, 1};
        vecs[9]  = '{1, 136,  8'd8,  8'd0, 1, 0, 0, 0, 1};
        vecs[10] = '{0, 287,  8'd255,8'd0, 1, 0, 0, 1, 1};
        vecs[11] = '{0, 288,  8'd0,  8'd0, 0, 0, 0, 1, 1};
        vecs[12] = '{0, 327,  8'd0,  8'd0, 0, 0, 0, 1, 1};
        vecs[13] = '{0, 328,  8'd0,  8'd0, 0, 0, 0, 0, 1};
        vecs[14] = '{0, 375,  8'd0,  8'd0, 0, 0, 0, 0, 1};
        vecs[15] = '{0, 376,  8'd0,  8'd0, 0, 0, 0, 1, 1};
        vecs[16] = '{0, 399,  8'd0,  8'd0, 0, 0, 0, 1, 1};
        vecs[17] = '{0, 832,  8'd0,  8'd1, 1, 0, 0, 1, 1};
        vecs[18] = '{0, 1487, 8'd255,8'd1, 1, 0, 0, 1, 1};
        vecs[19] = '{0, 1700, 8'd68, 8'd2, 1, 0, 0, 1, 1};

        reset_pulse(3);
        line0_hs_low = 0; line0_vis = 0; sf_wr = 0; sf_vb = 0; sf_vs_low = 0;
        stats_on = 1'b1;

        for (int i = 0; i < 20; i++) begin
            logic [28:0] act;
            run_to(vecs[i].t);
            act = vecs[i].sel ? small_vec() : full_vec();
            check($sformatf("vec%0d", i), {8'd0, act[20:0]},
                  {8'd0, vecs[i].cx, vecs[i].cy, vecs[i].vis, vecs[i].wr,
                   vecs[i].vb, vecs[i].hs, vecs[i].vs});
        end
        stats_on = 1'b0;
        check("line0_hsync_low", 29'(line0_hs_low), 29'd48);
        check("line0_visible",   29'(line0_vis),    29'd256);
        check("frame_writable",  29'(sf_wr),        29'd42);
        check("frame_vblank",    29'(sf_vb),        29'd1);
        check("frame_vsync_low", 29'(sf_vs_low),    29'd14);

        // One-clock reset mid-frame on the default geometry (line 10, hcount 200).
        run_to(4200);
        reset_pulse(1);

        // Random run lengths interrupted by random-length resets.
        for (int k = 0; k < 10; k++) begin
            int run_len;
            run_len = int'($urandom_range(300, 1));
            repeat (run_len) tick();
            reset_pulse(int'($urandom_range(3, 1)));
        end

        // Long run over 257 small frames.
        for (int n = 0; n < 257 * SMALL_FRAME + 20; n++) begin
            tick();
`ifdef VIDEO_TIMING_FRAME_COUNTER_EN
            if (t == 83)                      check("fc_before_first", {21'd0, s_fc}, 29'd0);
            if (t == 84)                      check("fc_first_vblank", {21'd0, s_fc}, 29'd1);
            if (t == 84 + 254 * SMALL_FRAME)  check("fc_reach_255",    {21'd0, s_fc}, 29'd255);
            if (t == 84 + 255 * SMALL_FRAME)  check("fc_wrap",         {21'd0, s_fc}, 29'd0);
`endif
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
